// File: rtl/cec_pkg.sv
// Shared CEC definitions for the receiver and CEC_Transmitter.
// Holds the nominal bus timing at 27 MHz, the 17-bit timer type and the
// receiver state encoding.
package cec_pkg;

  localparam int unsigned TIMER_W = 17;
  typedef logic [TIMER_W-1:0] timer_t;

  localparam timer_t START_LOW_MIN = 17'd94_500;   // 3.5 ms
  localparam timer_t START_LOW_MAX = 17'd105_300;  // 3.9 ms
  localparam timer_t START_PER_MIN = 17'd116_100;  // 4.3 ms
  localparam timer_t START_PER_MAX = 17'd126_900;  // 4.7 ms
  localparam timer_t BIT_PER_MIN   = 17'd55_350;   // 2.05 ms
  localparam timer_t BIT_PER_MAX   = 17'd74_250;   // 2.75 ms
  localparam timer_t BIT_LOW_MAX   = 17'd45_900;   // 1.7 ms
  localparam timer_t SAMPLE_TIME   = 17'd28_350;   // 1.05 ms
  localparam timer_t ACK_LOW_TIME  = 17'd40_500;   // 1.5 ms

  typedef enum logic [1:0] {
    IDLE,
    START_LOW,
    START_HIGH,
    BIT
  } rx_state_t;

endpackage

// File: rtl/cec_receiver_if.sv
// CEC receiver signal bundle: pad side (cec_in, cec_send, cec_out),
// configuration (my_addr, tx_active) and the block strobe towards the
// frame logic (data_valid, data_in, data_eom, data_broadcast,
// frame_error, busy).
//   master : the receiver
//   slave  : pad / frame logic side
interface cec_receiver_if;
  logic       cec_in;
  logic [3:0] my_addr;
  logic       tx_active;
  logic       cec_send;
  logic       cec_out;
  logic       data_valid;
  logic [7:0] data_in;
  logic       data_eom;
  logic       data_broadcast;
  logic       frame_error;
  logic       busy;

  modport master (
    input  cec_in, my_addr, tx_active,
    output cec_send, cec_out, data_valid, data_in, data_eom,
           data_broadcast, frame_error, busy
  );

  modport slave (
    output cec_in, my_addr, tx_active,
    input  cec_send, cec_out, data_valid, data_in, data_eom,
           data_broadcast, frame_error, busy
  );
endinterface

// File: rtl/cec_input_sync.sv
// Two-flop synchronizer for the asynchronous CEC pad plus a registered
// edge detector. level_o/fall_o/rise_o are aligned: an edge appears 3
// cycles after the pad changes, together with the new level.
//   clk, rst_n : clock, async active-low reset
//   cec_i      : raw pad level
//   level_o    : synchronized level
//   fall_o     : one-cycle falling-edge pulse
//   rise_o     : one-cycle rising-edge pulse
module cec_input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cec_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);
  logic s1_q, s2_q, lvl_q, fall_q, rise_q;

  // Resets to the idle-high bus level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      lvl_q  <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= cec_i;
      s2_q   <= s1_q;
      lvl_q  <= s2_q;
      fall_q <= lvl_q & ~s2_q;
      rise_q <= ~lvl_q & s2_q;
    end
  end

  assign level_o = lvl_q;
  assign fall_o  = fall_q;
  assign rise_o  = rise_q;
endmodule

// File: rtl/cec_receiver.sv
// CEC line receiver. Decodes start bit, 8 data bits, EOM and ACK, drives
// the ACK low pulse for blocks addressed to this device and presents each
// received block as a one-cycle strobe.
//   clk   : 27 MHz clock
//   rst_n : asynchronous active-low reset
//   bus   : cec_receiver_if.master (pad, my_addr, tx_active, block outputs)
module cec_receiver #(
  parameter cec_pkg::timer_t START_LOW_MIN = cec_pkg::START_LOW_MIN,
  parameter cec_pkg::timer_t START_LOW_MAX = cec_pkg::START_LOW_MAX,
  parameter cec_pkg::timer_t START_PER_MIN = cec_pkg::START_PER_MIN,
  parameter cec_pkg::timer_t START_PER_MAX = cec_pkg::START_PER_MAX,
  parameter cec_pkg::timer_t BIT_PER_MIN   = cec_pkg::BIT_PER_MIN,
  parameter cec_pkg::timer_t BIT_PER_MAX   = cec_pkg::BIT_PER_MAX,
  parameter cec_pkg::timer_t BIT_LOW_MAX   = cec_pkg::BIT_LOW_MAX,
  parameter cec_pkg::timer_t SAMPLE_TIME   = cec_pkg::SAMPLE_TIME,
  parameter cec_pkg::timer_t ACK_LOW_TIME  = cec_pkg::ACK_LOW_TIME
) (
  input logic            clk,
  input logic            rst_n,
  cec_receiver_if.master bus
);
  import cec_pkg::timer_t;
  import cec_pkg::rx_state_t;
  import cec_pkg::IDLE;
  import cec_pkg::START_LOW;
  import cec_pkg::START_HIGH;
  import cec_pkg::BIT;

  // Timer is 0 in the cycle after the detected fall, so the drive is
  // released after ACK_LOW_TIME cycles when it reaches this value.
  localparam timer_t ACK_LAST = ACK_LOW_TIME - 1'b1;

  logic level, fall, rise;

  cec_input_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .cec_i  (bus.cec_in),
    .level_o(level),
    .fall_o (fall),
    .rise_o (rise)
  );

  rx_state_t  state_q, state_d;
  timer_t     timer_q, timer_d;
  logic [3:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic       eom_q, eom_d;
  logic       first_q, first_d;
  logic       addr_q, addr_d;
  logic       bcast_q, bcast_d;
  logic       ack_q, ack_d;
  logic       valid_q, valid_d;
  logic [7:0] dout_q, dout_d;
  logic       deom_q, deom_d;
  logic       dbc_q, dbc_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      eom_q     <= 1'b0;
      first_q   <= 1'b0;
      addr_q    <= 1'b0;
      bcast_q   <= 1'b0;
      ack_q     <= 1'b0;
      valid_q   <= 1'b0;
      dout_q    <= '0;
      deom_q    <= 1'b0;
      dbc_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      eom_q     <= eom_d;
      first_q   <= first_d;
      addr_q    <= addr_d;
      bcast_q   <= bcast_d;
      ack_q     <= ack_d;
      valid_q   <= valid_d;
      dout_q    <= dout_d;
      deom_q    <= deom_d;
      dbc_q     <= dbc_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = fall ? '0 : ((timer_q == '1) ? timer_q : timer_q + 1'b1);
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    eom_d     = eom_q;
    first_d   = first_q;
    addr_d    = addr_q;
    bcast_d   = bcast_q;
    ack_d     = ack_q;
    valid_d   = 1'b0;
    dout_d    = dout_q;
    deom_d    = deom_q;
    dbc_d     = dbc_q;
    err_d     = 1'b0;

    // The ACK pulse outlives the FSM when EOM=1 returns it to IDLE early.
    if (ack_q && timer_q == ACK_LAST) ack_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall) state_d = START_LOW;
      end
      START_LOW: begin
        if (rise) begin
          if (timer_q >= START_LOW_MIN && timer_q <= START_LOW_MAX) state_d = START_HIGH;
          else err_d = 1'b1;
        end else if (timer_q > START_LOW_MAX) begin
          err_d = 1'b1;
        end
      end
      START_HIGH: begin
        if (fall) begin
          if (timer_q >= START_PER_MIN && timer_q <= START_PER_MAX) begin
            state_d   = BIT;
            bit_idx_d = '0;
            first_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (timer_q > START_PER_MAX) begin
          err_d = 1'b1;
        end
      end
      BIT: begin
        // Edge is checked before the sample point so a runt bit errors out.
        if (fall) begin
          if (timer_q < BIT_PER_MIN || timer_q > BIT_PER_MAX) err_d = 1'b1;
          else if (bit_idx_q == 4'd9 && addr_q && !bcast_q) ack_d = 1'b1;
        end else if (timer_q > BIT_PER_MAX) begin
          err_d = 1'b1;
        end else if (!level && !ack_q && timer_q > BIT_LOW_MAX) begin
          err_d = 1'b1;
        end else if (timer_q == SAMPLE_TIME) begin
          if (bit_idx_q < 4'd8) begin
            shreg_d   = {shreg_q[6:0], level};
            bit_idx_d = bit_idx_q + 4'd1;
          end else if (bit_idx_q == 4'd8) begin
            eom_d     = level;
            bit_idx_d = 4'd9;
            // Header destination is known here, in time to decide the ACK.
            if (first_q) begin
              bcast_d = (shreg_q[3:0] == 4'hF);
              addr_d  = (shreg_q[3:0] == bus.my_addr);
            end
          end else begin
            if (addr_q || bcast_q) begin
              valid_d = 1'b1;
              dout_d  = shreg_q;
              deom_d  = eom_q;
              dbc_d   = bcast_q;
            end
            first_d   = 1'b0;
            bit_idx_d = '0;
            if (eom_q) state_d = IDLE;
          end
        end
      end
    endcase

    if (err_d) begin
      state_d = IDLE;
      ack_d   = 1'b0;
    end

    if (bus.tx_active) begin
      state_d = IDLE;
      err_d   = 1'b0;
      valid_d = 1'b0;
      ack_d   = 1'b0;
    end
  end

  assign bus.cec_send       = ack_q;
  assign bus.cec_out        = ~ack_q;
  assign bus.data_valid     = valid_q;
  assign bus.data_in        = dout_q;
  assign bus.data_eom       = deom_q;
  assign bus.data_broadcast = dbc_q;
  assign bus.frame_error    = err_q;
  assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_cec_receiver.sv
// Bench for cec_receiver. Bus timing is scaled to 100 cycles per ms so a
// run stays short; windows keep the nominal ratios. The pad is a
// wired-AND of the initiator drive and the receiver's own ACK drive.
module tb_cec_receiver;

  localparam int SLMIN = 350, SLMAX = 390, SPMIN = 430, SPMAX = 470;
  localparam int BPMIN = 205, BPMAX = 275, BLMAX = 170, SAMP = 105, ACK_T = 150;

  typedef struct packed {
    logic       err;
    logic [7:0] d;
    logic       eom;
    logic       bc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drv = 1'b1;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned last_fall_cyc = 0;
  int unsigned last_err_cyc = 0;
  int unsigned ack_seen = 0;
  int unsigned ack_exp = 0;
  int unsigned ack_w = 0;
  bit          in_ack = 1'b0;
  exp_t        sb[$];
  logic [7:0]  fbytes[4];

  cec_receiver_if bus();

  assign bus.cec_in = drv & ~(bus.cec_send & ~bus.cec_out);

  cec_receiver #(
    .START_LOW_MIN(17'd350), .START_LOW_MAX(17'd390),
    .START_PER_MIN(17'd430), .START_PER_MAX(17'd470),
    .BIT_PER_MIN  (17'd205), .BIT_PER_MAX  (17'd275),
    .BIT_LOW_MAX  (17'd170), .SAMPLE_TIME  (17'd105),
    .ACK_LOW_TIME (17'd150)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic err, input logic [7:0] d, input logic eom, input logic bc);
    exp_t e;
    e.err = err; e.d = d; e.eom = eom; e.bc = bc;
    return e;
  endfunction

  // Scoreboard monitor: every strobe consumes one expected event.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (rst_n && (bus.data_valid || bus.frame_error)) begin
      if (bus.frame_error) last_err_cyc = cyc;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_strobe: valid=%0b err=%0b data=%02h, required no strobe",
                 bus.data_valid, bus.frame_error, bus.data_in);
      end else begin
        e  = sb.pop_front();
        ok = (bus.frame_error == e.err) && (bus.data_valid == !e.err) &&
             (e.err || (bus.data_in == e.d && bus.data_eom == e.eom && bus.data_broadcast == e.bc));
        if (!ok) begin
          n_bad++;
          $display("FAIL block: got valid=%0b err=%0b d=%02h eom=%0b bc=%0b, required err=%0b d=%02h eom=%0b bc=%0b",
                   bus.data_valid, bus.frame_error, bus.data_in, bus.data_eom, bus.data_broadcast,
                   e.err, e.d, e.eom, e.bc);
        end
      end
    end
  end

  // ACK drive monitor: counts pulses and checks each complete pulse width.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_ack = 1'b0;
      ack_w  = 0;
    end else if (bus.cec_send) begin
      if (!in_ack) begin
        ack_seen++;
        check("ack_level", bus.cec_out, 0);
      end
      in_ack = 1'b1;
      ack_w++;
    end else if (in_ack) begin
      in_ack = 1'b0;
      check("ack_width", ack_w, ACK_T);
      ack_w = 0;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    int per, low;
    per = 225 + int'($urandom_range(0, 30));
    low = v ? 50 + int'($urandom_range(0, 20)) : 140 + int'($urandom_range(0, 20));
    drv = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(low);
    drv = 1'b1;
    wait_cyc(per - low);
  endtask

  task automatic send_start();
    int low, per;
    low = 360 + int'($urandom_range(0, 20));
    per = 440 + int'($urandom_range(0, 20));
    drv = 1'b0;
    wait_cyc(low);
    drv = 1'b1;
    wait_cyc(per - low);
  endtask

  task automatic send_head(input logic [7:0] b, input logic eom);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(eom);
  endtask

  task automatic end_checks();
    check("busy_idle", bus.busy, 0);
    check("ack_pulses", ack_seen, ack_exp);
    check("pending_events", sb.size(), 0);
  endtask

  // Model: destination nibble of the header decides addressed/broadcast
  // for the whole frame; strobes only when either holds, ACK only when
  // addressed and not broadcast. trunc: last block has EOM=0 then silence.
  task automatic run_frame(input logic [3:0] me, input int nb, input bit trunc);
    logic bc, ad, eom;
    int   dt;
    bus.my_addr = me;
    bc = (fbytes[0][3:0] == 4'hF);
    ad = (fbytes[0][3:0] == me);
    for (int k = 0; k < nb; k++) begin
      eom = (k == nb - 1) && !trunc;
      if (ad || bc) sb.push_back(mk(1'b0, fbytes[k], eom, bc));
      if (ad && !bc) ack_exp++;
    end
    if (trunc) sb.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0));
    send_start();
    for (int k = 0; k < nb; k++) begin
      send_head(fbytes[k], (k == nb - 1) && !trunc);
      send_bit(1'b1);
    end
    if (trunc) begin
      wait_cyc(BPMAX + 40);
      dt = int'(last_err_cyc - last_fall_cyc);
      n_cmp++;
      if (dt < BPMAX + 1 || dt > BPMAX + 8) begin
        n_bad++;
        $display("FAIL timeout_timing: error %0d cycles after last fall, required %0d..%0d",
                 dt, BPMAX + 1, BPMAX + 8);
      end
    end
    wait_cyc(60);
    end_checks();
  endtask

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] me, dest;
    int         nb, sel;
    bus.my_addr   = 4'h0;
    bus.tx_active = 1'b0;
    rst_n = 1'b0;
    drv   = 1'b1;
    wait_cyc(3);
    check("rst_cec_send", bus.cec_send, 0);
    check("rst_cec_out", bus.cec_out, 1);
    check("rst_data_valid", bus.data_valid, 0);
    check("rst_data_in", bus.data_in, 0);
    check("rst_data_eom", bus.data_eom, 0);
    check("rst_data_broadcast", bus.data_broadcast, 0);
    check("rst_frame_error", bus.frame_error, 0);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    wait_cyc(20);

    // Addressed header, EOM=1: one strobe, one ACK pulse.
    fbytes[0] = 8'h40;
    run_frame(4'h0, 1, 1'b0);
    wait_cyc(100);

    // Broadcast header plus one data block: two strobes, no ACK drive.
    fbytes[0] = 8'h4F; fbytes[1] = 8'h36;
    run_frame(4'h3, 2, 1'b0);
    wait_cyc(100);

    // Header for someone else: silent.
    fbytes[0] = 8'h45;
    run_frame(4'h0, 1, 1'b0);
    wait_cyc(100);

    // Short start-bit low (3.2 ms): error on the rise, then a good frame.
    bus.my_addr = 4'h0;
    sb.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0));
    drv = 1'b0;
    wait_cyc(320);
    drv = 1'b1;
    wait_cyc(100);
    check("short_start_idle", bus.busy, 0);
    check("short_start_events", sb.size(), 0);
    fbytes[0] = 8'h30;
    run_frame(4'h0, 1, 1'b0);
    wait_cyc(100);

    // Header with EOM=0, then the line stays high: timeout error.
    fbytes[0] = 8'h40;
    run_frame(4'h0, 1, 1'b1);
    wait_cyc(100);

    // Reset during the ACK drive releases the pad asynchronously.
    bus.my_addr = 4'h0;
    ack_exp++;
    send_start();
    send_head(8'h40, 1'b1);
    drv = 1'b0;
    wait_cyc(50);
    check("ack_active", bus.cec_send, 1);
    check("ack_drive_low", bus.cec_out, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_send", bus.cec_send, 0);
    check("async_rst_out", bus.cec_out, 1);
    drv = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(400);
    end_checks();

    // tx_active mid-frame forces IDLE without an error.
    bus.my_addr = 4'h2;
    send_start();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus.tx_active = 1'b1;
    wait_cyc(2);
    check("tx_active_idle", bus.busy, 0);
    wait_cyc(400);
    bus.tx_active = 1'b0;
    wait_cyc(50);
    end_checks();

    // Randomized frames.
    for (int f = 0; f < 5; f++) begin
      me   = 4'($urandom_range(0, 14));
      sel  = int'($urandom_range(0, 2));
      dest = (sel == 0) ? me : (sel == 1) ? 4'hF : 4'($urandom);
      nb   = int'($urandom_range(1, 3));
      fbytes[0] = {4'($urandom), dest};
      for (int k = 1; k < 4; k++) fbytes[k] = 8'($urandom);
      run_frame(me, nb, 1'b0);
      wait_cyc(100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
